// File: rtl/bram_log_ctrl.sv
// BRAM capture-address controller: one-shot or circular logging with optional decimation.
// Optional feature macro: LOG_DECIM_EN (defined = keep 1 of every decim+1 valid samples).
module bram_log_ctrl #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024,
   parameter int DEC_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              stop,
   input  logic              circ,
   input  logic [DEC_W-1:0]  decim,
   input  logic              valid_in,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              busy,
   output logic              done,
   output logic              wrapped
);

   typedef enum logic {
      IDLE    = 1'b0,
      WRITING = 1'b1
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t state;
   state_t state_nxt;
   logic   circ_q;
   logic   accept;
   logic   last_addr;
   logic   finish;

   assign busy      = (state == WRITING);
   assign last_addr = (wr_addr == LAST_ADDR);

`ifdef LOG_DECIM_EN
   logic [DEC_W-1:0] decim_q;
   logic [DEC_W-1:0] dec_cnt;

   // Reset gates the strobe so the BRAM never sees a write in a reset cycle.
   assign accept = !rst && (state == WRITING) && valid_in && (dec_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         decim_q <= '0;
         dec_cnt <= '0;
      end else if (state == IDLE) begin
         if (run) begin
            decim_q <= decim;
            dec_cnt <= '0;
         end
      end else if (valid_in) begin
         dec_cnt <= (dec_cnt == '0) ? decim_q : dec_cnt - 1'b1;
      end
   end
`else
   logic unused_decim;
   assign unused_decim = ^decim;
   assign accept       = !rst && (state == WRITING) && valid_in;
`endif

   assign wr_en = accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Capture ends on the last one-shot write or on any stop in circular mode.
   always_comb begin
      state_nxt = state;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (run) begin
               state_nxt = WRITING;
            end
         end
         WRITING: begin
            if ((accept && last_addr && !circ_q) || (circ_q && stop)) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
      endcase
   end

   // wr_addr and wrapped are left untouched in IDLE so software can find the buffer head.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_addr <= '0;
         wrapped <= 1'b0;
         circ_q  <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= finish;
         if (state == IDLE) begin
            if (run) begin
               wr_addr <= '0;
               wrapped <= 1'b0;
               circ_q  <= circ;
            end
         end else if (accept) begin
            if (last_addr) begin
               wr_addr <= '0;
               if (circ_q) begin
                  wrapped <= 1'b1;
               end
            end else begin
               wr_addr <= wr_addr + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bram_log_ctrl.sv
// Bench for bram_log_ctrl: directed capture scenarios plus random traffic against a
// count-based reference model (sample k of a capture is kept when k mod (decim+1) == 0).
module tb_bram_log_ctrl;

   localparam int ADDR_W = 4;
   localparam int DEPTH  = 8;
   localparam int DEC_W  = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              run = 1'b0;
   logic              stop = 1'b0;
   logic              circ = 1'b0;
   logic [DEC_W-1:0]  decim = '0;
   logic              valid_in = 1'b0;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              busy;
   logic              done;
   logic              wrapped;

   int checks   = 0;
   int failures = 0;
   int n_wr     = 0;
   logic [ADDR_W-1:0] exp_q[$];

   // Reference model state
   bit m_busy    = 1'b0;
   bit m_circ    = 1'b0;
   bit m_wrapped = 1'b0;
   bit m_done    = 1'b0;
   int m_addr    = 0;
   int m_dec     = 0;
   int m_vcnt    = 0;

   always #5 clk = ~clk;

   bram_log_ctrl #(
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH),
      .DEC_W (DEC_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .stop    (stop),
      .circ    (circ),
      .decim   (decim),
      .valid_in(valid_in),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .busy    (busy),
      .done    (done),
      .wrapped (wrapped)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs at the falling edge, advance the model.
   task automatic step(input bit r, input bit rn, input bit sp, input bit ci,
                       input int dc, input bit v);
      bit exp_we;
      bit fin;
      @(posedge clk);
      #1;
      rst = r; run = rn; stop = sp; circ = ci; decim = DEC_W'(dc); valid_in = v;
      @(negedge clk);
      exp_we = !r && m_busy && v && ((m_vcnt % (m_dec + 1)) == 0);
      check("wr_en",   wr_en,   exp_we);
      check("busy",    busy,    m_busy);
      check("done",    done,    m_done);
      check("wrapped", wrapped, m_wrapped);
      check("wr_addr", wr_addr, m_addr);
      if (exp_we) exp_q.push_back(ADDR_W'(m_addr));
      if (wr_en === 1'b1) begin
         n_wr++;
         if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
         else check("wr_q", wr_addr, exp_q.pop_front());
      end
      if (r) begin
         m_busy = 0; m_addr = 0; m_wrapped = 0; m_done = 0;
      end else if (!m_busy) begin
         m_done = 0;
         if (rn) begin
            m_busy = 1; m_circ = ci; m_addr = 0; m_wrapped = 0; m_vcnt = 0;
`ifdef LOG_DECIM_EN
            m_dec = dc;
`else
            m_dec = 0;
`endif
         end
      end else begin
         fin = 0;
         if (exp_we) begin
            m_addr = (m_addr + 1) % DEPTH;
            if (m_addr == 0) begin
               if (m_circ) m_wrapped = 1;
               else fin = 1;
            end
         end
         if (m_circ && sp) fin = 1;
         if (v) m_vcnt++;
         m_done = fin;
         if (fin) m_busy = 0;
      end
   endtask

   initial begin
      // Reset
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 1, 1, 0, 1);
      step(0, 0, 0, 0, 0, 1);

      // One-shot, no decimation, continuous valid
      n_wr = 0;
      step(0, 1, 0, 0, 0, 1);
      for (int i = 0; i < 11; i++) step(0, 0, 0, 0, 0, 1);
      check("n_wr_oneshot", n_wr, 8);

      // One-shot, decimation 2
      n_wr = 0;
      step(0, 1, 0, 0, 2, 1);
      for (int i = 0; i < 28; i++) step(0, 0, 0, 0, 2, 1);
      check("n_wr_decim", n_wr, 8);

      // Circular, 11 accepts then stop
      n_wr = 0;
      step(0, 1, 0, 1, 0, 0);
      for (int i = 0; i < 11; i++) step(0, 0, 0, 1, 0, 1);
      step(0, 0, 1, 1, 0, 0);
      step(0, 0, 0, 1, 0, 1);
      check("circ_head", wr_addr, 3);
      check("circ_wrapped", wrapped, 1);
      check("circ_done", done, 1);
      check("n_wr_circ", n_wr, 11);

      // Circular, stop coincides with last-address accept
      n_wr = 0;
      step(0, 1, 0, 1, 0, 0);
      for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0, 1);
      step(0, 0, 1, 1, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 1);
      check("n_wr_stop_last", n_wr, 8);
      check("stop_last_wrapped", wrapped, 1);

      // Reset in the middle of a capture
      n_wr = 0;
      step(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      check("abort_n_wr", n_wr, 4);
      check("abort_busy", busy, 0);
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      check("restart_addr", wr_addr, 0);
      for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 1);

      // Run held high across captures (circular with stop, then one-shot)
      step(0, 1, 0, 1, 0, 1);
      for (int i = 0; i < 10; i++) step(0, 1, 0, 1, 0, 1);
      step(0, 1, 1, 0, 0, 1);
      for (int i = 0; i < 22; i++) step(0, 1, 0, 0, 0, 1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), $urandom_range(0, 3) != 0);
      end

      check("q_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
